// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment vectors are active-high a..g (bit 0 = a, bit 6 = g) until polarity is applied.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
    localparam seg_t HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts an active-high pattern to the pin polarity of the board.
    function automatic seg_t seg_polarity(input seg_t s, input logic active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex.sv
// Combinational hex nibble to active-high segment pattern.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    // Table lookup; polarity is applied later at the output register.
    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver for the ALU result bus.
// A staging register takes load requests at any time; the shadow register that
// feeds the display is only updated on the frame boundary, so a frame never
// shows a mix of old and new digits. Each digit slot opens with a short
// all-off interval to suppress ghosting while the digit drivers switch.
// Optional build macro SEG7_DIM_EN adds a 4-bit brightness input that gates
// the lit part of each slot with a 16-phase PWM taken from the prescaler MSBs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int PRESCALE_W     = 10,
    parameter int BLANK_CYC      = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
`ifdef SEG7_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic                    load_ack,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_W-1:0] BLANK_END = PRESCALE_W'(BLANK_CYC);

    logic [PRESCALE_W-1:0]   presc;
    logic [IDX_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] staging;
    logic [NUM_DIGITS-1:0]   staging_dp;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;

    logic                    tick;
    logic                    frame_end;
    logic                    blanking;
    logic                    lit;
    logic [3:0]              nibble;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   onehot;
    seg_t                    digit_seg;

    assign tick      = &presc;
    assign frame_end = ena & tick & (dig_idx == LAST_IDX);
    assign blanking  = (presc < BLANK_END);

    // The pulses are decoded from registered state so they line up with the
    // boundary edge itself; a load in the same cycle is acknowledged at once.
    assign frame_done = frame_end;
    assign load_ack   = frame_end & (pending | load);

    // Refresh prescaler and digit index; the index advances once per slot.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            presc   <= '0;
            dig_idx <= '0;
        end else if (ena) begin
            presc <= presc + 1'b1;
            if (tick) begin
                dig_idx <= (dig_idx == LAST_IDX) ? '0 : dig_idx + 1'b1;
            end
        end
    end

    // Staging takes every load; shadow only moves on the frame boundary.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            staging    <= '0;
            staging_dp <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else if (ena) begin
            if (load) begin
                staging    <= data_in;
                staging_dp <= dp_in;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (load) begin
                    shadow    <= data_in;
                    shadow_dp <= dp_in;
                end else if (pending) begin
                    shadow    <= staging;
                    shadow_dp <= staging_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select the nibble, decimal point and enable bit of the digit in its slot.
    always_comb begin
        nibble = '0;
        cur_dp = 1'b0;
        onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_idx == IDX_W'(k)) begin
                nibble    = shadow[4*k +: 4];
                cur_dp    = shadow_dp[k];
                onehot[k] = 1'b1;
            end
        end
    end

    hex_to_7seg u_hex (
        .nibble (nibble),
        .seg    (digit_seg)
    );

`ifdef SEG7_DIM_EN
    logic [3:0] brightness_q;
    logic [3:0] pwm_phase;

    assign pwm_phase = presc[PRESCALE_W-1 -: 4];
    assign lit       = !blanking && (pwm_phase <= brightness_q);

    // Brightness changes take effect at slot boundaries only, keeping each slot's duty consistent.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            brightness_q <= 4'hF;
        end else if (ena && tick) begin
            brightness_q <= brightness;
        end
    end
`else
    assign lit = !blanking;
`endif

    // Registered pin drivers; blanked slots drive segments and digits inactive.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            seg    <= seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);
            dp     <= SEG_ACTIVE_LOW;
            dig_en <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else if (ena) begin
            seg    <= seg_polarity(lit ? digit_seg : SEG_BLANK, SEG_ACTIVE_LOW);
            dp     <= (lit & cur_dp) ^ SEG_ACTIVE_LOW;
            dig_en <= (lit ? onehot : '0) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (PRESCALE_W=4, BLANK_CYC=2, 2 digits, active-high).
// Load requests push the expected display onto a queue; the queue is popped when
// load_ack is seen and the following frame is compared against it.
module tb_seg7_scan_driver;

    typedef struct {
        logic [6:0] s0;
        logic [6:0] s1;
        logic       p0;
        logic       p1;
    } disp_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       ena = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] dp_in = 2'b00;
    logic       load_ack;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dig_en;
    logic       frame_done;
`ifdef SEG7_DIM_EN
    logic [3:0] brightness = 4'hF;
`endif

    int    n_checks = 0;
    int    n_pass = 0;
    disp_t exp_q[$];
    disp_t cur;
    bit    q_pending = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS     (2),
        .PRESCALE_W     (4),
        .BLANK_CYC      (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
`ifdef SEG7_DIM_EN
        .brightness (brightness),
`endif
        .load_ack   (load_ack),
        .seg        (seg),
        .dp         (dp),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic disp_t make_disp(input logic [7:0] d, input logic [1:0] p);
        disp_t r;
        r.s0 = exp_seg(d[3:0]);
        r.s1 = exp_seg(d[7:4]);
        r.p0 = p[0];
        r.p1 = p[1];
        return r;
    endfunction

    // A newer load replaces a still-pending one: last one wins.
    task automatic push_load(input logic [7:0] d, input logic [1:0] p);
        if (q_pending && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(make_disp(d, p));
        q_pending = 1'b1;
    endtask

    task automatic pop_load();
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        q_pending = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_frame(input int limit, output int cnt, output bit found, output int acks);
        cnt = 0;
        found = 1'b0;
        acks = 0;
        while (!found && cnt < limit) begin
            step();
            cnt++;
            #1;
            if (load_ack === 1'b1) acks++;
            if (frame_done === 1'b1) found = 1'b1;
        end
    endtask

    // Runs one frame starting from a frame_done cycle, optionally issuing a load at slot k.
    task automatic capture_frame(input int ld_k, input logic [7:0] ld_data, input logic [1:0] ld_dp,
                                 output logic [6:0] s0, output logic [6:0] s1,
                                 output logic p0, output logic p1,
                                 output logic [1:0] e0, output logic [1:0] e1,
                                 output int ack_cnt, output logic ack_end, output logic fd_end);
        s0 = '0; s1 = '0; p0 = 1'b0; p1 = 1'b0; e0 = '0; e1 = '0;
        ack_cnt = 0; ack_end = 1'b0; fd_end = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == ld_k) begin
                load = 1'b1;
                data_in = ld_data;
                dp_in = ld_dp;
                push_load(ld_data, ld_dp);
            end else begin
                load = 1'b0;
            end
            #1;
            if (k == 10) begin s0 = seg; p0 = dp; e0 = dig_en; end
            if (k == 26) begin s1 = seg; p1 = dp; e1 = dig_en; end
            if (k < 32 && load_ack === 1'b1) ack_cnt++;
            if (k == 32) begin ack_end = load_ack; fd_end = frame_done; end
        end
    endtask

    task automatic test_reset();
        int  cnt, acks;
        bit  found;
        logic [1:0] exp_en;
        rstb = 1'b0;
        repeat (3) step();
        #1;
        n_checks++; if (seg !== 7'h00) $display("FAIL reset_seg got %h want 00", seg); else n_pass++;
        n_checks++; if (dp !== 1'b0) $display("FAIL reset_dp got %b want 0", dp); else n_pass++;
        n_checks++; if (dig_en !== 2'b00) $display("FAIL reset_dig_en got %b want 00", dig_en); else n_pass++;
        n_checks++; if (load_ack !== 1'b0) $display("FAIL reset_load_ack got %b want 0", load_ack); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
        rstb = 1'b1;
        cur = make_disp(8'h00, 2'b00);
        for (int n = 1; n <= 3; n++) begin
            step();
            #1;
            exp_en = (n < 3) ? 2'b00 : 2'b01;
            n_checks++;
            if (dig_en !== exp_en) $display("FAIL release_dig_en cyc %0d got %b want %b", n, dig_en, exp_en);
            else n_pass++;
        end
        n_checks++; if (seg !== 7'h3F) $display("FAIL release_seg got %h want 3f", seg); else n_pass++;
        wait_frame(60, cnt, found, acks);
        n_checks++;
        if (!found || cnt != 28) $display("FAIL first_frame_done found %0d after %0d want 28", found, cnt);
        else n_pass++;
    endtask

    task automatic test_scan();
        int q, p, d;
        logic [1:0] exp_en;
        logic [6:0] exp_s;
        logic exp_fd;
        for (int k = 1; k <= 64; k++) begin
            step();
            #1;
            if (k == 1) begin
                exp_en = 2'b10;
            end else begin
                q = k - 2;
                p = q % 16;
                d = (q / 16) % 2;
                exp_en = (p < 2) ? 2'b00 : ((d == 0) ? 2'b01 : 2'b10);
            end
            exp_s = (exp_en != 2'b00) ? 7'h3F : 7'h00;
            exp_fd = (k == 32 || k == 64);
            n_checks++;
            if (dig_en !== exp_en) $display("FAIL scan_dig_en k=%0d got %b want %b", k, dig_en, exp_en);
            else n_pass++;
            n_checks++;
            if (seg !== exp_s) $display("FAIL scan_seg k=%0d got %h want %h", k, seg, exp_s);
            else n_pass++;
            n_checks++;
            if (frame_done !== exp_fd) $display("FAIL scan_frame_done k=%0d got %b want %b", k, frame_done, exp_fd);
            else n_pass++;
        end
    endtask

    task automatic test_load();
        logic [6:0] s0, s1;
        logic p0, p1, ack_end, fd_end;
        logic [1:0] e0, e1;
        int ack_cnt;
        capture_frame(5, 8'hA5, 2'b00, s0, s1, p0, p1, e0, e1, ack_cnt, ack_end, fd_end);
        n_checks++; if (s0 !== cur.s0) $display("FAIL load_no_tear_d0 got %h want %h", s0, cur.s0); else n_pass++;
        n_checks++; if (s1 !== cur.s1) $display("FAIL load_no_tear_d1 got %h want %h", s1, cur.s1); else n_pass++;
        n_checks++; if (ack_cnt != 0) $display("FAIL load_early_ack got %0d want 0", ack_cnt); else n_pass++;
        n_checks++; if (fd_end !== 1'b1) $display("FAIL load_boundary_fd got %b want 1", fd_end); else n_pass++;
        n_checks++; if (ack_end !== 1'b1) $display("FAIL load_ack_boundary got %b want 1", ack_end); else n_pass++;
        if (ack_end === 1'b1) pop_load();
        capture_frame(0, 8'h00, 2'b00, s0, s1, p0, p1, e0, e1, ack_cnt, ack_end, fd_end);
        n_checks++; if (s0 !== cur.s0) $display("FAIL load_d0 got %h want %h", s0, cur.s0); else n_pass++;
        n_checks++; if (s1 !== cur.s1) $display("FAIL load_d1 got %h want %h", s1, cur.s1); else n_pass++;
        n_checks++; if (e0 !== 2'b01) $display("FAIL load_en0 got %b want 01", e0); else n_pass++;
        n_checks++; if (e1 !== 2'b10) $display("FAIL load_en1 got %b want 10", e1); else n_pass++;
        n_checks++; if (ack_cnt != 0 || ack_end !== 1'b0) $display("FAIL load_ack_once got %0d/%b want 0/0", ack_cnt, ack_end); else n_pass++;
    endtask

    task automatic test_coincident();
        logic [6:0] s0, s1;
        logic p0, p1, ack_end, fd_end;
        logic [1:0] e0, e1;
        int ack_cnt;
        load = 1'b1;
        data_in = 8'h3C;
        dp_in = 2'b01;
        push_load(8'h3C, 2'b01);
        #1;
        n_checks++;
        if (load_ack !== 1'b1 || frame_done !== 1'b1)
            $display("FAIL coincident_ack got ack=%b fd=%b want 1/1", load_ack, frame_done);
        else n_pass++;
        if (load_ack === 1'b1) pop_load();
        capture_frame(0, 8'h00, 2'b00, s0, s1, p0, p1, e0, e1, ack_cnt, ack_end, fd_end);
        n_checks++; if (s0 !== cur.s0) $display("FAIL coincident_d0 got %h want %h", s0, cur.s0); else n_pass++;
        n_checks++; if (s1 !== cur.s1) $display("FAIL coincident_d1 got %h want %h", s1, cur.s1); else n_pass++;
        n_checks++; if (p0 !== cur.p0 || p1 !== cur.p1) $display("FAIL coincident_dp got %b%b want %b%b", p1, p0, cur.p1, cur.p0); else n_pass++;
        n_checks++; if (ack_cnt != 0 || ack_end !== 1'b0) $display("FAIL coincident_no_reack got %0d/%b want 0/0", ack_cnt, ack_end); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] s0, s1;
        logic p0, p1, ack_end, fd_end;
        logic [1:0] e0, e1;
        int ack_cnt;
        ack_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            load = 1'b0;
            if (k == 5) begin load = 1'b1; data_in = 8'h11; dp_in = 2'b00; push_load(8'h11, 2'b00); end
            if (k == 6) begin load = 1'b1; data_in = 8'h22; dp_in = 2'b10; push_load(8'h22, 2'b10); end
            #1;
            if (k < 32 && load_ack === 1'b1) ack_cnt++;
        end
        n_checks++; if (ack_cnt != 0) $display("FAIL b2b_early_ack got %0d want 0", ack_cnt); else n_pass++;
        n_checks++;
        if (load_ack !== 1'b1 || frame_done !== 1'b1)
            $display("FAIL b2b_boundary got ack=%b fd=%b want 1/1", load_ack, frame_done);
        else n_pass++;
        n_checks++; if (exp_q.size() != 1) $display("FAIL b2b_queue got %0d entries want 1", exp_q.size()); else n_pass++;
        if (load_ack === 1'b1) pop_load();
        capture_frame(0, 8'h00, 2'b00, s0, s1, p0, p1, e0, e1, ack_cnt, ack_end, fd_end);
        n_checks++; if (s0 !== cur.s0) $display("FAIL b2b_d0 got %h want %h", s0, cur.s0); else n_pass++;
        n_checks++; if (s1 !== cur.s1) $display("FAIL b2b_d1 got %h want %h", s1, cur.s1); else n_pass++;
        n_checks++; if (p0 !== cur.p0 || p1 !== cur.p1) $display("FAIL b2b_dp got %b%b want %b%b", p1, p0, cur.p1, cur.p0); else n_pass++;
    endtask

    task automatic test_ena();
        logic [6:0] s0, s1;
        logic p0, p1, ack_end, fd_end;
        logic [1:0] e0, e1;
        int ack_cnt, cnt, acks;
        bit found;
        repeat (8) step();
        #1;
        ena = 1'b0;
        load = 1'b1;
        data_in = 8'hFF;
        dp_in = 2'b11;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            n_checks++;
            if (seg !== cur.s0 || dig_en !== 2'b01)
                $display("FAIL ena_frozen i=%0d got seg=%h en=%b want %h/01", i, seg, dig_en, cur.s0);
            else n_pass++;
            n_checks++;
            if (load_ack !== 1'b0 || frame_done !== 1'b0)
                $display("FAIL ena_pulses i=%0d got ack=%b fd=%b want 0/0", i, load_ack, frame_done);
            else n_pass++;
        end
        ena = 1'b1;
        load = 1'b0;
        wait_frame(60, cnt, found, acks);
        n_checks++;
        if (!found || cnt != 24) $display("FAIL ena_slot_extend found %0d after %0d want 24", found, cnt);
        else n_pass++;
        n_checks++; if (load_ack !== 1'b0) $display("FAIL ena_load_ignored_ack got %b want 0", load_ack); else n_pass++;
        capture_frame(0, 8'h00, 2'b00, s0, s1, p0, p1, e0, e1, ack_cnt, ack_end, fd_end);
        n_checks++; if (s0 !== cur.s0 || s1 !== cur.s1) $display("FAIL ena_load_ignored got %h/%h want %h/%h", s0, s1, cur.s0, cur.s1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] s0, s1;
        logic p0, p1, ack_end, fd_end;
        logic [1:0] e0, e1;
        int ack_cnt, cnt, acks;
        bit found;
        for (int k = 1; k <= 8; k++) begin
            step();
            load = (k == 5);
            if (k == 5) begin data_in = 8'h77; dp_in = 2'b11; push_load(8'h77, 2'b11); end
        end
        #1;
        rstb = 1'b0;
        #1;
        n_checks++;
        if (dig_en !== 2'b00 || seg !== 7'h00 || dp !== 1'b0)
            $display("FAIL midreset_outputs got en=%b seg=%h dp=%b want 00/00/0", dig_en, seg, dp);
        else n_pass++;
        exp_q.delete();
        q_pending = 1'b0;
        cur = make_disp(8'h00, 2'b00);
        repeat (2) step();
        rstb = 1'b1;
        wait_frame(60, cnt, found, acks);
        n_checks++;
        if (!found || cnt != 31) $display("FAIL midreset_frame found %0d after %0d want 31", found, cnt);
        else n_pass++;
        n_checks++; if (acks != 0) $display("FAIL midreset_pending_lost got %0d acks want 0", acks); else n_pass++;
        capture_frame(0, 8'h00, 2'b00, s0, s1, p0, p1, e0, e1, ack_cnt, ack_end, fd_end);
        n_checks++; if (s0 !== cur.s0 || s1 !== cur.s1) $display("FAIL midreset_display got %h/%h want %h/%h", s0, s1, cur.s0, cur.s1); else n_pass++;
        n_checks++; if (ack_end !== 1'b0) $display("FAIL midreset_ack got %b want 0", ack_end); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_coincident();
        test_back_to_back();
        test_ena();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
